// File: rtl/config_frame_sequencer_pkg.sv
// config_frame_sequencer_pkg: shared constants, command field positions and FSM states
package config_frame_sequencer_pkg;
    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
    localparam int END_BIT   = 31;
    localparam int COL_MSB   = 30;
    localparam int COL_LSB   = 24;
    localparam int FRAME_MSB = 23;
    localparam int FRAME_LSB = 16;
    typedef enum logic [2:0] {IDLE, HDR, LOAD, SKIP, STROBE} state_t;
endpackage

// File: rtl/config_frame_sequencer_if.sv
// config_frame_sequencer_if: valid/ready word stream from the bitstream loader
interface config_frame_sequencer_if #(parameter int W = 32) ();
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    modport master (output s_data, s_valid, input s_ready);
    modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer: turns a sync+command+data word stream into FrameData/FrameStrobe writes
module config_frame_sequencer
    import config_frame_sequencer_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 16,
    parameter int NumColumns      = 10,
    parameter int StrobeCycles    = 2
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    config_frame_sequencer_if.slave               s,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  config_active,
    output logic                                  done,
    output logic                                  err
);
    localparam int NS = NumColumns * MaxFramesPerCol;
    localparam int RW = $clog2(NumRows);
    localparam int SW = StrobeCycles > 1 ? $clog2(StrobeCycles) : 1;
    localparam int IW = $clog2(NS);
    localparam logic [6:0]    NCOL = 7'(NumColumns);
    localparam logic [7:0]    NFRM = 8'(MaxFramesPerCol);
    localparam logic [RW-1:0] LAST_ROW = RW'(NumRows - 1);
    localparam logic [SW-1:0] LAST_STB = SW'(StrobeCycles - 1);

    state_t        state;
    logic [RW-1:0] row;
    logic [SW-1:0] scnt;
    logic [IW-1:0] idx;
    logic          acc;
    logic [6:0]    col_f;
    logic [7:0]    frm_f;

    assign acc   = s.s_valid && s.s_ready;
    assign col_f = s.s_data[COL_MSB:COL_LSB];
    assign frm_f = s.s_data[FRAME_MSB:FRAME_LSB];

    // Single FSM: decodes commands, fills rows, and holds the one-hot strobe for StrobeCycles
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            row           <= '0;
            scnt          <= '0;
            idx           <= '0;
            s.s_ready     <= 1'b0;
            FrameData     <= '0;
            FrameStrobe   <= '0;
            config_active <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    s.s_ready <= 1'b1;
                    if (acc && s.s_data == SYNC_WORD) begin
                        config_active <= 1'b1;
                        err           <= 1'b0;
                        state         <= HDR;
                    end
                end
                HDR: if (acc) begin
                    row <= '0;
                    if (s.s_data[END_BIT]) begin
                        done          <= 1'b1;
                        config_active <= 1'b0;
                        state         <= IDLE;
                    end else if (col_f >= NCOL || frm_f >= NFRM) begin
                        err   <= 1'b1;
                        state <= SKIP;
                    end else begin
                        idx   <= IW'(32'(col_f) * MaxFramesPerCol + 32'(frm_f));
                        state <= LOAD;
                    end
                end
                LOAD: if (acc) begin
                    FrameData[row*FrameBitsPerRow +: FrameBitsPerRow] <= s.s_data;
                    row <= row + 1'b1;
                    if (row == LAST_ROW) begin
                        s.s_ready   <= 1'b0;
                        FrameStrobe <= NS'(1) << idx;
                        scnt        <= '0;
                        state       <= STROBE;
                    end
                end
                SKIP: if (acc) begin
                    row <= row + 1'b1;
                    if (row == LAST_ROW) state <= HDR;
                end
                STROBE: begin
                    if (scnt == LAST_STB) begin
                        FrameStrobe <= '0;
                        s.s_ready   <= 1'b1;
                        state       <= HDR;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_frame_sequencer.sv
// tb_config_frame_sequencer: directed checks of sync, load, skip, strobe timing and reset
module tb_config_frame_sequencer;
    import config_frame_sequencer_pkg::*;

    logic         CLK = 1'b0;
    logic         resetn = 1'b0;
    logic [511:0] FrameData;
    logic [199:0] FrameStrobe;
    logic         config_active, done, err;
    logic [511:0] exp_fd = '0;

    config_frame_sequencer_if sif ();

    config_frame_sequencer dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .s             (sif),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .config_active (config_active),
        .done          (done),
        .err           (err)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, run = 0, cur_idx = 0, cur_start = 0, onehot_bad = 0, done_cnt = 0;
    int pulse_idx[$], pulse_len[$], pulse_start[$];

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    function automatic logic [199:0] onehot(input int i);
        logic [199:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] cmd(input logic [6:0] c, input logic [7:0] f);
        return {1'b0, c, f, 16'h0000};
    endfunction

    task automatic clear_pulses();
        pulse_idx.delete();
        pulse_len.delete();
        pulse_start.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Presents one word and returns #1 after the edge that accepted it
    task automatic send(input logic [31:0] w, input bit rnd = 1'b0);
        int k = 0;
        if (rnd) for (int j = 0; j < 4 && $urandom_range(1) == 1; j++) tick(1);
        sif.s_data  = w;
        sif.s_valid = 1'b1;
        @(negedge CLK);
        while (!sif.s_ready && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (!sif.s_ready) chk("send_timeout", 1'b0, 1'b1);
        tick(1);
        sif.s_valid = 1'b0;
    endtask

    task automatic frame(input logic [6:0] c, input logic [7:0] f, input logic [31:0] base, input bit rnd);
        send(cmd(c, f), rnd);
        for (int r = 0; r < 16; r++) send(base + 32'(r), rnd);
    endtask

    task automatic model_fd(input logic [31:0] base);
        for (int r = 0; r < 16; r++) exp_fd[r*32 +: 32] = base + 32'(r);
    endtask

    // Strobe/done monitor sampled on the falling edge
    initial forever begin
        @(negedge CLK);
        cyc++;
        if (done) done_cnt++;
        if ($countones(FrameStrobe) > 1) onehot_bad++;
        if (FrameStrobe != '0) begin
            if (run == 0) begin
                cur_start = cyc;
                for (int i = 0; i < 200; i++) if (FrameStrobe[i]) cur_idx = i;
            end
            run++;
        end else if (run != 0) begin
            pulse_idx.push_back(cur_idx);
            pulse_len.push_back(run);
            pulse_start.push_back(cur_start);
            run = 0;
        end
    end

    initial begin
        sif.s_data  = '0;
        sif.s_valid = 1'b0;
        #12;
        chk("rst_ready", sif.s_ready, 1'b0);
        chk("rst_fd", FrameData, '0);
        chk("rst_strobe", FrameStrobe, '0);
        chk("rst_active", config_active, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge CLK);
        resetn = 1'b1;
        tick(1);

        send(32'h1234_5678);
        chk("t1_junk_inactive", config_active, 1'b0);
        send(SYNC_WORD);
        chk("t1_sync_active", config_active, 1'b1);
        chk("t1_sync_err", err, 1'b0);
        chk("t1_no_pulse", pulse_idx.size(), 0);

        frame(7'd2, 8'd5, 32'h100, 1'b0);
        model_fd(32'h100);
        chk("t2_strobe_c1", FrameStrobe, onehot(45));
        chk("t2_ready_c1", sif.s_ready, 1'b0);
        tick(1);
        chk("t2_strobe_c2", FrameStrobe, onehot(45));
        chk("t2_ready_c2", sif.s_ready, 1'b0);
        tick(1);
        chk("t2_strobe_off", FrameStrobe, '0);
        chk("t2_ready_back", sif.s_ready, 1'b1);
        chk("t2_fd", FrameData, exp_fd);
        send({1'b1, 31'h0});
        chk("t2_done", done, 1'b1);
        chk("t2_inactive", config_active, 1'b0);
        tick(1);
        chk("t2_done_fall", done, 1'b0);
        chk("t2_done_cnt", done_cnt, 1);

        send(SYNC_WORD);
        clear_pulses();
        frame(7'd2, 8'd5, 32'h300, 1'b1);
        model_fd(32'h300);
        tick(3);
        chk("t3_fd", FrameData, exp_fd);
        chk("t3_npulse", pulse_idx.size(), 1);
        chk("t3_idx", pulse_idx.size() > 0 ? pulse_idx[0] : -1, 45);
        chk("t3_len", pulse_len.size() > 0 ? pulse_len[0] : -1, 2);

        clear_pulses();
        send(cmd(7'd0, 8'd20));
        chk("t4_err", err, 1'b1);
        for (int r = 0; r < 16; r++) send(32'hDEAD_0000 + 32'(r));
        tick(3);
        chk("t4_fd_kept", FrameData, exp_fd);
        chk("t4_no_pulse", pulse_idx.size(), 0);
        chk("t4_active", config_active, 1'b1);
        frame(7'd0, 8'd0, 32'h200, 1'b0);
        model_fd(32'h200);
        tick(3);
        chk("t4_npulse", pulse_idx.size(), 1);
        chk("t4_idx", pulse_idx.size() > 0 ? pulse_idx[0] : -1, 0);
        chk("t4_fd", FrameData, exp_fd);
        chk("t4_err_held", err, 1'b1);
        send({1'b1, 31'h0});
        chk("t4_err_after_end", err, 1'b1);
        send(SYNC_WORD);
        chk("t4_err_cleared", err, 1'b0);

        clear_pulses();
        frame(7'd9, 8'd19, 32'h400, 1'b0);
        frame(7'd0, 8'd0, 32'h500, 1'b0);
        model_fd(32'h500);
        tick(3);
        chk("t6_npulse", pulse_idx.size(), 2);
        chk("t6_idx0", pulse_idx.size() > 1 ? pulse_idx[0] : -1, 199);
        chk("t6_idx1", pulse_idx.size() > 1 ? pulse_idx[1] : -1, 0);
        chk("t6_len0", pulse_len.size() > 1 ? pulse_len[0] : -1, 2);
        chk("t6_len1", pulse_len.size() > 1 ? pulse_len[1] : -1, 2);
        chk("t6_spacing", pulse_start.size() > 1 ? pulse_start[1] - pulse_start[0] : -1, 19);
        chk("t6_fd", FrameData, exp_fd);
        chk("onehot", onehot_bad, 0);

        clear_pulses();
        frame(7'd1, 8'd1, 32'h600, 1'b0);
        chk("t5_strobe_c1", FrameStrobe, onehot(21));
        #1 resetn = 1'b0;
        #1;
        chk("t5_strobe_async", FrameStrobe, '0);
        chk("t5_ready_rst", sif.s_ready, 1'b0);
        chk("t5_active_rst", config_active, 1'b0);
        @(negedge CLK);
        resetn = 1'b1;
        tick(2);
        chk("t5_ready_idle", sif.s_ready, 1'b1);
        chk("t5_fd_rst", FrameData, '0);
        frame(7'd1, 8'd1, 32'h700, 1'b0);
        tick(3);
        chk("t5_need_sync", config_active, 1'b0);
        chk("t5_no_pulse", pulse_idx.size(), 0);
        chk("t5_fd_unchanged", FrameData, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
